// File: rtl/wrr_arb_pkg.sv
// Shared defaults for the weighted round-robin arbiter tree.
// Width-dependent types are declared locally in each module.
package wrr_arb_pkg;

    localparam int unsigned DefNumIn       = 4;
    localparam int unsigned DefDataWidth   = 32;
    localparam int unsigned DefWeightWidth = 4;

endpackage : wrr_arb_pkg

// File: rtl/wrr_arb_tree_rr_prio_select.sv
// Circular first-one finder: the lowest set request at or above start wins,
// otherwise the lowest set request overall. idx is 0 when nothing requests.
module rr_prio_select #(
    parameter int unsigned NumIn    = 4,
    parameter int unsigned IdxWidth = (NumIn > 32'd1) ? $clog2(NumIn) : 32'd1
) (
    input  logic [NumIn-1:0]    req,
    input  logic [IdxWidth-1:0] start,
    output logic [IdxWidth-1:0] idx,
    output logic                empty
);

    typedef logic [IdxWidth-1:0] idx_t;

    idx_t upper_idx;
    idx_t lower_idx;
    logic upper_hit;
    logic lower_hit;

    // Two leading-zero scans: one over the masked upper part, one over the full vector.
    // Scanning downward lets the lowest matching index overwrite the others.
    always_comb begin
        upper_idx = '0;
        lower_idx = '0;
        upper_hit = 1'b0;
        lower_hit = 1'b0;
        for (int i = NumIn - 1; i >= 0; i--) begin
            if (req[i] && (i >= int'(start))) begin
                upper_hit = 1'b1;
                upper_idx = idx_t'(i);
            end
            if (req[i]) begin
                lower_hit = 1'b1;
                lower_idx = idx_t'(i);
            end
        end
    end

    assign idx   = upper_hit ? upper_idx : lower_idx;
    assign empty = ~lower_hit;

endmodule : rr_prio_select

// File: rtl/wrr_arb_tree.sv
// Weighted round-robin N:1 stream arbiter with payload mux and optional lock-in.
// Each input may win up to its weight in consecutive handshakes before priority rotates.
module wrr_arb_tree
    import wrr_arb_pkg::*;
#(
    parameter int unsigned NumIn       = DefNumIn,
    parameter int unsigned DataWidth   = DefDataWidth,
    parameter type         DataType    = logic [DataWidth-1:0],
    parameter int unsigned WeightWidth = DefWeightWidth,
    parameter bit          LockIn      = 1'b1,
    parameter bit          AxiVldRdy   = 1'b0,
    parameter int unsigned IdxWidth    = (NumIn > 32'd1) ? $clog2(NumIn) : 32'd1
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic                              flush_i,
    input  logic [NumIn-1:0][WeightWidth-1:0] weight_i,
    input  logic [NumIn-1:0]                  req_i,
    output logic [NumIn-1:0]                  gnt_o,
    input  DataType                           data_i [NumIn],
    output logic                              req_o,
    input  logic                              gnt_i,
    output DataType                           data_o,
    output logic [IdxWidth-1:0]               idx_o
);

    typedef logic [IdxWidth-1:0]    idx_t;
    typedef logic [WeightWidth-1:0] weight_t;

    idx_t             rr_q, rr_d;
    weight_t          cnt_q, cnt_d;
    logic             lock_q, lock_d;
    logic [NumIn-1:0] req_q, req_d;

    idx_t             win;
    idx_t             next_idx;
    weight_t          w_eff;
    logic [WeightWidth:0] cnt_inc;
    logic             empty;
    logic             hs;

    // While locked the previously presented request vector is replayed,
    // so the winner cannot move until the downstream accepts.
    assign req_d = (LockIn && lock_q) ? req_q : req_i;

    rr_prio_select #(
        .NumIn    (NumIn),
        .IdxWidth (IdxWidth)
    ) u_prio_select (
        .req   (req_d),
        .start (rr_q),
        .idx   (win),
        .empty (empty)
    );

    assign req_o    = ~empty;
    assign hs       = req_o & gnt_i;
    assign idx_o    = req_o ? win : '0;
    assign next_idx = (win == idx_t'(NumIn - 1)) ? '0 : win + idx_t'(1);
    assign w_eff    = (weight_i[win] == '0) ? weight_t'(1) : weight_i[win];
    assign cnt_inc  = {1'b0, cnt_q} + {{WeightWidth{1'b0}}, 1'b1};

    always_comb begin
        gnt_o      = '0;
        gnt_o[win] = gnt_i & (AxiVldRdy | req_d[win]);
        data_o     = '0;
        if (req_o) begin
            data_o = data_i[win];
        end
    end

    // Burst accounting: the widened increment compares against the current weight,
    // so a weight lowered mid-burst forces an advance without wrapping the counter.
    always_comb begin
        rr_d   = rr_q;
        cnt_d  = cnt_q;
        lock_d = LockIn & req_o & ~gnt_i;
        if (hs) begin
            if (win == rr_q) begin
                if (cnt_inc >= {1'b0, w_eff}) begin
                    rr_d  = next_idx;
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_inc[WeightWidth-1:0];
                end
            end else if (w_eff == weight_t'(1)) begin
                rr_d  = next_idx;
                cnt_d = '0;
            end else begin
                rr_d  = win;
                cnt_d = weight_t'(1);
            end
        end
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q   <= '0;
            cnt_q  <= '0;
            lock_q <= 1'b0;
            req_q  <= '0;
        end else if (flush_i) begin
            rr_q   <= '0;
            cnt_q  <= '0;
            lock_q <= 1'b0;
            req_q  <= '0;
        end else begin
            rr_q   <= rr_d;
            cnt_q  <= cnt_d;
            lock_q <= lock_d;
            req_q  <= req_d;
        end
    end

endmodule : wrr_arb_tree

// File: tb/tb_wrr_arb_tree.sv
// Self-checking bench for wrr_arb_tree: directed scenarios followed by random
// traffic, all compared against a rule-level reference model.
module tb_wrr_arb_tree;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int WW = 4;
    localparam int IW = 2;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 flush = 1'b0;
    logic [N-1:0][WW-1:0] weight;
    logic [N-1:0]         req_i;
    logic [N-1:0]         gnt_o;
    logic [DW-1:0]        data_in [N];
    logic                 req_o;
    logic                 gnt_i = 1'b0;
    logic [DW-1:0]        data_o;
    logic [IW-1:0]        idx_o;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int           m_rr;
    int           m_cnt;
    bit           m_lock;
    logic [N-1:0] m_reqq;
    logic [N-1:0] e_reqd;
    int           e_w;
    bit           e_valid;

    always #5 clk = ~clk;

    wrr_arb_tree #(
        .NumIn       (N),
        .DataWidth   (DW),
        .DataType    (logic [DW-1:0]),
        .WeightWidth (WW),
        .LockIn      (1'b1),
        .AxiVldRdy   (1'b0)
    ) dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .flush_i  (flush),
        .weight_i (weight),
        .req_i    (req_i),
        .gnt_o    (gnt_o),
        .data_i   (data_in),
        .req_o    (req_o),
        .gnt_i    (gnt_i),
        .data_o   (data_o),
        .idx_o    (idx_o)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_rr   = 0;
        m_cnt  = 0;
        m_lock = 1'b0;
        m_reqq = '0;
    endtask

    // Winner = first requester met when walking circularly from the priority holder.
    task automatic model_eval();
        e_reqd  = m_lock ? m_reqq : req_i;
        e_valid = 1'b0;
        e_w     = 0;
        for (int k = 0; k < N; k++) begin
            int j;
            j = (m_rr + k) % N;
            if (!e_valid && e_reqd[j]) begin
                e_valid = 1'b1;
                e_w     = j;
            end
        end
    endtask

    task automatic compare(input string tag);
        logic [N-1:0]  eg;
        logic [DW-1:0] ed;
        model_eval();
        eg = '0;
        ed = '0;
        if (e_valid) begin
            ed = data_in[e_w];
            if (gnt_i) eg[e_w] = 1'b1;
        end
        check({tag, ".req_o"}, 64'(req_o), 64'(e_valid));
        check({tag, ".idx_o"}, 64'(idx_o), e_valid ? 64'(e_w) : 64'd0);
        check({tag, ".data_o"}, 64'(data_o), 64'(ed));
        check({tag, ".gnt_o"}, 64'(gnt_o), 64'(eg));
    endtask

    task automatic advance();
        int wt;
        @(posedge clk);
        if (rst_n) begin
            if (flush) begin
                model_reset();
            end else begin
                if (e_valid && gnt_i) begin
                    wt = (weight[e_w] == '0) ? 1 : int'(weight[e_w]);
                    if (e_w == m_rr) begin
                        if (m_cnt + 1 >= wt) begin
                            m_rr  = (e_w + 1) % N;
                            m_cnt = 0;
                        end else begin
                            m_cnt = m_cnt + 1;
                        end
                    end else if (wt == 1) begin
                        m_rr  = (e_w + 1) % N;
                        m_cnt = 0;
                    end else begin
                        m_rr  = e_w;
                        m_cnt = 1;
                    end
                end
                m_lock = e_valid && !gnt_i;
                m_reqq = e_reqd;
            end
        end
        #1;
    endtask

    task automatic step(input string tag, input int exp_idx);
        #3;
        compare(tag);
        if (exp_idx >= 0) check({tag, ".dir_idx"}, 64'(idx_o), 64'(exp_idx));
        advance();
    endtask

    task automatic check_state(input string tag, input int rr, input int cnt);
        check({tag, ".rr_q"}, 64'(dut.rr_q), 64'(rr));
        check({tag, ".cnt_q"}, 64'(dut.cnt_q), 64'(cnt));
    endtask

    task automatic do_flush();
        flush = 1'b1;
        step("flush", -1);
        flush = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int seq_eq[5] = '{0, 1, 2, 3, 0};
        int seq_w[10] = '{0, 0, 0, 1, 2, 2, 3, 0, 0, 0};
        int tog_rr[3] = '{2, 3, 2};
        int tog_cnt[3] = '{1, 0, 1};

        model_reset();
        req_i  = '0;
        weight = '0;
        for (int i = 0; i < N; i++) data_in[i] = $urandom;

        // Reset state
        #3;
        compare("reset");
        check_state("reset", 0, 0);
        check("reset.lock_q", 64'(dut.lock_q), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Equal weights, everyone requesting
        for (int i = 0; i < N; i++) weight[i] = WW'(1);
        req_i = 4'b1111;
        gnt_i = 1'b1;
        for (int i = 0; i < 5; i++) step("equal", seq_eq[i]);

        // Weights {3,1,2,1}
        do_flush();
        weight[0] = WW'(3); weight[1] = WW'(1); weight[2] = WW'(2); weight[3] = WW'(1);
        for (int i = 0; i < 10; i++) step("weighted", seq_w[i]);

        // Single requester with weight 2: priority toggles, winner stays
        do_flush();
        for (int i = 0; i < N; i++) weight[i] = WW'(2);
        req_i = 4'b0100;
        for (int i = 0; i < 3; i++) begin
            step("single", 2);
            check_state("single", tog_rr[i], tog_cnt[i]);
        end

        // Lock-in under back-pressure
        do_flush();
        req_i = 4'b0011;
        gnt_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step("lock", 0);
            req_i = 4'b0010;
            check("lock.lock_q", 64'(dut.lock_q), 64'd1);
        end
        gnt_i = 1'b1;
        #3;
        compare("lock_rel");
        check("lock_rel.gnt_o", 64'(gnt_o), 64'h1);
        advance();

        // Weight lowered mid-burst
        do_flush();
        weight[0] = WW'(5); weight[1] = WW'(1); weight[2] = WW'(1); weight[3] = WW'(1);
        req_i = 4'b1111;
        step("midburst", 0);
        step("midburst", 0);
        check_state("midburst", 0, 2);
        weight[0] = WW'(1);
        step("midburst", 0);
        check_state("midburst_adv", 1, 0);

        // Flush and async reset in the middle of a burst
        do_flush();
        for (int i = 0; i < N; i++) weight[i] = WW'(2);
        req_i = 4'b0100;
        step("preflush", 2);
        check_state("preflush", 2, 1);
        flush = 1'b1;
        step("flushpulse", 2);
        flush = 1'b0;
        check_state("flushpulse", 0, 0);
        check("flushpulse.lock_q", 64'(dut.lock_q), 64'd0);
        step("prereset", 2);
        check_state("prereset", 2, 1);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_state("async_rst", 0, 0);
        check("async_rst.lock_q", 64'(dut.lock_q), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        req_i = 4'b1111;
        step("postreset", 0);

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            req_i = N'($urandom);
            gnt_i = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 31) == 0);
            for (int i = 0; i < N; i++) begin
                weight[i]  = WW'($urandom_range(0, 15));
                data_in[i] = $urandom;
            end
            step("rnd", -1);
            check_state("rnd", m_rr, m_cnt);
        end
        flush = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_wrr_arb_tree
